cas_sort_pipe: RTL and testbench

- Parametrised, pipelined compare-and-swap sorting network; successor to the 3-input, 4-bit combinational sorter.
- Sorts NUM_INPUTS unsigned BITS-wide values per transaction using an odd-even transposition network.
- One register stage per network layer; accepts one vector per cycle with valid/ready flow control on both sides.
- Sits between stochastic-to-binary converters and downstream rank/median logic in the DSC datapath.

---
 rtl/cas_pkg.sv | 32 +++
 rtl/cas_sort_pipe_cas2.sv | 34 +++
 rtl/cas_sort_pipe.sv | 119 +++++++++++
 tb/tb_cas_sort_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// Shared constants and helpers for the compare-and-swap sorting pipeline.
// Optional tag tracking is enabled by defining CAS_TAG_EN.
package cas_pkg;

  localparam int MAX_INPUTS = 16;
  localparam int MAX_BITS   = 32;
  localparam int BUS_W      = MAX_INPUTS * MAX_BITS;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Extract lane idx of a bus packed as bits-wide lanes.
  function automatic logic [MAX_BITS-1:0] lane_sel(
    input logic [BUS_W-1:0] bus,
    input int               idx,
    input int               bits
  );
    logic [BUS_W-1:0]    sh;
    logic [MAX_BITS-1:0] m;
    sh = bus >> (idx * bits);
    m  = '1;
    m  = m >> (MAX_BITS - bits);
    return sh[MAX_BITS-1:0] & m;
  endfunction

endpackage

// File: rtl/cas_sort_pipe_cas2.sv
// Combinational compare-and-swap cell; hi_* lands in the lower lane index.
// Tag ports exist only when CAS_TAG_EN is defined.
module cas2 #(
  parameter int BITS = 4
`ifdef CAS_TAG_EN
  , parameter int TAG_W = 2
`endif
) (
  input  logic [BITS-1:0]  a,
  input  logic [BITS-1:0]  b,
`ifdef CAS_TAG_EN
  input  logic [TAG_W-1:0] tag_a,
  input  logic [TAG_W-1:0] tag_b,
  output logic [TAG_W-1:0] hi_tag,
  output logic [TAG_W-1:0] lo_tag,
`endif
  input  logic             descending,
  output logic [BITS-1:0]  hi_d,
  output logic [BITS-1:0]  lo_d
);

  logic swap;

  // Strict compare: equal keys never move, which keeps the sort stable.
  assign swap = descending ? (a < b) : (a > b);
  assign hi_d = swap ? b : a;
  assign lo_d = swap ? a : b;

`ifdef CAS_TAG_EN
  assign hi_tag = swap ? tag_b : tag_a;
  assign lo_tag = swap ? tag_a : tag_b;
`endif

endmodule

// File: rtl/cas_sort_pipe.sv
// Pipelined odd-even transposition sorter, one register per network layer.
// Define CAS_TAG_EN to carry original lane indices through to out_tags.
module cas_sort_pipe
  import cas_pkg::*;
#(
  parameter int BITS       = 4,
  parameter int NUM_INPUTS = 3,
  parameter bit DESCENDING = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_INPUTS*BITS-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_INPUTS*BITS-1:0] out_data
`ifdef CAS_TAG_EN
  , output logic [NUM_INPUTS*clog2(NUM_INPUTS)-1:0] out_tags
`endif
);

  localparam int N = NUM_INPUTS;
`ifdef CAS_TAG_EN
  localparam int TAG_W = clog2(N);
`endif

  // Register 0 holds the raw input; register s+1 holds layer s output.
  logic [BITS-1:0] dat_q [N+1][N];
  logic [BITS-1:0] nxt   [N][N];
  logic [N:0]      vld_q;
  logic            adv;

`ifdef CAS_TAG_EN
  logic [TAG_W-1:0] tag_q [N+1][N];
  logic [TAG_W-1:0] tnxt  [N][N];
`endif

  assign out_valid = vld_q[N];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar s = 0; s < N; s++) begin : g_stage
    for (genvar i = 0; i < N; i++) begin : g_lane
      if (((i % 2) == (s % 2)) && ((i + 1) < N)) begin : g_cas
        cas2 #(
          .BITS (BITS)
`ifdef CAS_TAG_EN
          , .TAG_W(TAG_W)
`endif
        ) u_cas (
          .a         (dat_q[s][i]),
          .b         (dat_q[s][i+1]),
`ifdef CAS_TAG_EN
          .tag_a     (tag_q[s][i]),
          .tag_b     (tag_q[s][i+1]),
          .hi_tag    (tnxt[s][i]),
          .lo_tag    (tnxt[s][i+1]),
`endif
          .descending(DESCENDING),
          .hi_d      (nxt[s][i]),
          .lo_d      (nxt[s][i+1])
        );
      end else if (!((i > 0) && (((i - 1) % 2) == (s % 2)))) begin : g_pass
        assign nxt[s][i] = dat_q[s][i];
`ifdef CAS_TAG_EN
        assign tnxt[s][i] = tag_q[s][i];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s <= N; s++) begin
        for (int i = 0; i < N; i++) begin
          dat_q[s][i] <= '0;
`ifdef CAS_TAG_EN
          tag_q[s][i] <= '0;
`endif
        end
      end
    end else if (adv) begin
      vld_q <= {vld_q[N-1:0], in_valid};
      for (int i = 0; i < N; i++) begin
        dat_q[0][i] <= BITS'(lane_sel(BUS_W'(in_data), i, BITS));
`ifdef CAS_TAG_EN
        tag_q[0][i] <= TAG_W'(i);
`endif
      end
      for (int s = 0; s < N; s++) begin
        for (int i = 0; i < N; i++) begin
          dat_q[s+1][i] <= nxt[s][i];
`ifdef CAS_TAG_EN
          tag_q[s+1][i] <= tnxt[s][i];
`endif
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data[i*BITS +: BITS] = dat_q[N][i];
    end
  end

`ifdef CAS_TAG_EN
  always_comb begin
    out_tags = '0;
    for (int i = 0; i < N; i++) begin
      out_tags[i*TAG_W +: TAG_W] = tag_q[N][i];
    end
  end
`endif

endmodule

// File: tb/tb_cas_sort_pipe.sv
// Bench for cas_sort_pipe: vector table, corner sequences, random stream
// against a sort-based reference model; covers CAS_TAG_EN when defined.
module tb_cas_sort_pipe;

  localparam int B  = 4;
  localparam int N  = 3;
  localparam int W  = N * B;
  localparam int TW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         ir_d, ov_d, ir_a, ov_a;
  logic [W-1:0] od_d, od_a;
`ifdef CAS_TAG_EN
  logic [N*TW-1:0] ot_d, ot_a;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  cas_sort_pipe #(.BITS(B), .NUM_INPUTS(N), .DESCENDING(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_d), .in_data(in_data),
    .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d)
`ifdef CAS_TAG_EN
    , .out_tags(ot_d)
`endif
  );

  cas_sort_pipe #(.BITS(B), .NUM_INPUTS(N), .DESCENDING(1'b0)) dut_asc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a)
`ifdef CAS_TAG_EN
    , .out_tags(ot_a)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [W-1:0] pk(input int a, input int b, input int c);
    return {c[3:0], b[3:0], a[3:0]};
  endfunction

  function automatic logic [5:0] tk(input int a, input int b, input int c);
    return {c[1:0], b[1:0], a[1:0]};
  endfunction

  // Reference: sort keys value*16+rank; rank encodes original lane for stability.
  task automatic ref_sort(input logic [W-1:0] v, input bit desc,
                          output logic [W-1:0] d, output logic [5:0] t);
    int q[$];
    int r;
    for (int i = 0; i < N; i++) begin
      r = desc ? 15 - i : i;
      q.push_back(int'(v[i*B +: B]) * 16 + r);
    end
    if (desc) q.rsort();
    else q.sort();
    d = '0;
    t = '0;
    for (int j = 0; j < N; j++) begin
      d[j*B +: B] = 4'(q[j] / 16);
      r = q[j] % 16;
      t[j*2 +: 2] = 2'(desc ? 15 - r : r);
    end
  endtask

  logic [W-1:0] m_v, m_ed, m_ea;
  logic [5:0]   m_td, m_ta;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      chk("lockstep_valid", 32'(ov_a), 32'(ov_d));
      if (ov_d && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          m_v = sb.pop_front();
          ref_sort(m_v, 1'b1, m_ed, m_td);
          ref_sort(m_v, 1'b0, m_ea, m_ta);
          chk("stream_desc", 32'(od_d), 32'(m_ed));
          chk("stream_asc", 32'(od_a), 32'(m_ea));
`ifdef CAS_TAG_EN
          chk("stream_tag_desc", 32'(ot_d), 32'(m_td));
          chk("stream_tag_asc", 32'(ot_a), 32'(m_ta));
`endif
        end
      end
      if (in_valid && ir_d) sb.push_back(in_data);
    end
  end

  typedef struct packed {
    logic [W-1:0] vin;
    logic [W-1:0] d;
    logic [W-1:0] a;
    logic [5:0]   td;
    logic [5:0]   ta;
  } vec_t;

  vec_t tbl[6];

  task automatic run_single(input vec_t v);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = v.vin;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov_d) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd3);
    chk("tbl_desc", 32'(od_d), 32'(v.d));
    chk("tbl_asc", 32'(od_a), 32'(v.a));
`ifdef CAS_TAG_EN
    chk("tbl_tag_desc", 32'(ot_d), 32'(v.td));
    chk("tbl_tag_asc", 32'(ot_a), 32'(v.ta));
`endif
    @(negedge clk);
    chk("one_cycle", 32'(ov_d), 32'd0);
  endtask

  initial begin
    int cnt;
    int gaps;
    logic [W-1:0] held;

    tbl[0] = '{pk(3,9,5),   pk(9,5,3),   pk(3,5,9),   tk(1,2,0), tk(0,2,1)};
    tbl[1] = '{pk(7,7,2),   pk(7,7,2),   pk(2,7,7),   tk(0,1,2), tk(2,0,1)};
    tbl[2] = '{pk(15,0,15), pk(15,15,0), pk(0,15,15), tk(0,2,1), tk(1,0,2)};
    tbl[3] = '{pk(1,2,3),   pk(3,2,1),   pk(1,2,3),   tk(2,1,0), tk(0,1,2)};
    tbl[4] = '{pk(0,0,0),   pk(0,0,0),   pk(0,0,0),   tk(0,1,2), tk(0,1,2)};
    tbl[5] = '{pk(4,15,15), pk(15,15,4), pk(4,15,15), tk(1,2,0), tk(0,1,2)};

    @(negedge clk);
    chk("rst_valid", 32'(ov_d), 32'd0);
    chk("rst_data", 32'(od_d), 32'd0);
    chk("rst_ready", 32'(ir_d), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < 6; t++) run_single(tbl[t]);

    // two vectors in flight, then a mid-cycle reset
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = pk(1,14,6);
    @(posedge clk); #1;
    in_data  = pk(8,2,11);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(ov_d), 32'd0);
    chk("midrst_data", 32'(od_d), 32'd0);
    chk("midrst_ready", 32'(ir_d), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov_d) cnt++;
    end
    chk("no_out_after_rst", 32'(cnt), 32'd0);
    run_single(tbl[0]);

    // back-to-back random stream
    gaps = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = W'($urandom);
      @(negedge clk);
      if (k >= 4 && !ov_d) gaps++;
    end
    chk("stream_gaps", 32'(gaps), 32'd0);

    // downstream stall with a full pipe
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_data   = W'($urandom);
    @(negedge clk);
    held = od_d;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      in_data = W'($urandom);
      @(negedge clk);
      chk("stall_ready", 32'(ir_d), 32'd0);
      chk("stall_valid", 32'(ov_d), 32'd1);
      chk("stall_hold", 32'(od_d), 32'(held));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      in_data = W'($urandom);
    end

    // random valid/ready mix
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
    end

    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !ov_d) break;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(ov_d), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
